// File: rtl/scsu_ocp_mem_slave.sv
// OCP slave memory for the scsu master port: programmable accept wait-states, fixed read
// latency, byte-enabled posted writes, error responses and transaction counters.
module scsu_ocp_mem_slave #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  scsu_m_ocp_mcmd,
  input  logic [1:0]  scsu_m_ocp_mbyten,
  input  logic [12:0] scsu_m_ocp_maddr,
  input  logic [15:0] scsu_m_ocp_mdata,
  output logic        ocp_scsu_m_scmdaccept,
  output logic [15:0] ocp_scsu_m_sdata,
  output logic [1:0]  ocp_scsu_m_sresp,
  input  logic [3:0]  cfg_wait,
  output logic [15:0] wr_cnt,
  output logic [15:0] rd_cnt,
  output logic [7:0]  err_cnt,
  output logic        proto_err
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  LAT_LOAD = 4'(RD_LAT - 1);

  localparam logic [2:0] CMD_IDLE = 3'd0;
  localparam logic [2:0] CMD_WR   = 3'd1;
  localparam logic [2:0] CMD_RD   = 3'd2;
  localparam logic [1:0] RESP_DVA = 2'd1;
  localparam logic [1:0] RESP_ERR = 2'd3;

  typedef enum logic [1:0] {StIdle, StWait, StAcc, StResp} state_t;

  state_t      state;
  logic [3:0]  wcnt;
  logic [3:0]  lcnt;
  logic [1:0]  pend_resp;
  logic [15:0] pend_data;
  logic [15:0] mem [DEPTH];

  logic          addr_ok;
  logic [AW-1:0] idx;
  logic          rd_ok;
  logic [1:0]    acc_resp;
  logic [15:0]   acc_data;
  logic [7:0]    err_next;

  assign addr_ok = 32'(scsu_m_ocp_maddr) < DEPTH;
  assign idx     = scsu_m_ocp_maddr[AW-1:0];
  assign rd_ok   = (scsu_m_ocp_mcmd == CMD_RD) && addr_ok;

  // Response chosen at the accept edge; illegal commands fall through to ERR like a bad read.
  always_comb begin
    acc_resp = RESP_ERR;
    acc_data = 16'h0000;
    if (rd_ok) begin
      acc_resp = RESP_DVA;
      acc_data = mem[idx];
    end
  end

  assign err_next = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= StIdle;
      wcnt                  <= 4'd0;
      lcnt                  <= 4'd0;
      pend_resp             <= 2'd0;
      pend_data             <= 16'h0000;
      ocp_scsu_m_scmdaccept <= 1'b0;
      ocp_scsu_m_sdata      <= 16'h0000;
      ocp_scsu_m_sresp      <= 2'd0;
      wr_cnt                <= 16'h0000;
      rd_cnt                <= 16'h0000;
      err_cnt               <= 8'h00;
      proto_err             <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= 16'h0000;
      end
    end else begin
      ocp_scsu_m_scmdaccept <= 1'b0;
      proto_err             <= 1'b0;
      unique case (state)
        StIdle: begin
          if (scsu_m_ocp_mcmd != CMD_IDLE) begin
            wcnt <= cfg_wait;
            if (cfg_wait == 4'd0) begin
              state                 <= StAcc;
              ocp_scsu_m_scmdaccept <= 1'b1;
            end else begin
              state <= StWait;
            end
          end
        end
        StWait: begin
          wcnt <= wcnt - 4'd1;
          if (scsu_m_ocp_mcmd == CMD_IDLE) begin
            proto_err <= 1'b1;
            err_cnt   <= err_next;
            state     <= StIdle;
          end else if (wcnt == 4'd1) begin
            state                 <= StAcc;
            ocp_scsu_m_scmdaccept <= 1'b1;
          end
        end
        StAcc: begin
          if (scsu_m_ocp_mcmd == CMD_IDLE) begin
            // Command withdrawn during the accept cycle: same treatment as in WAIT.
            proto_err <= 1'b1;
            err_cnt   <= err_next;
            state     <= StIdle;
          end else if (scsu_m_ocp_mcmd == CMD_WR) begin
            if (addr_ok) begin
              if (scsu_m_ocp_mbyten[0]) mem[idx][7:0]  <= scsu_m_ocp_mdata[7:0];
              if (scsu_m_ocp_mbyten[1]) mem[idx][15:8] <= scsu_m_ocp_mdata[15:8];
              wr_cnt <= wr_cnt + 16'd1;
            end else begin
              err_cnt <= err_next;
            end
            state <= StIdle;
          end else begin
            if (rd_ok) begin
              rd_cnt <= rd_cnt + 16'd1;
            end else begin
              err_cnt <= err_next;
            end
            if (LAT_LOAD == 4'd0) begin
              ocp_scsu_m_sresp <= acc_resp;
              ocp_scsu_m_sdata <= acc_data;
            end
            pend_resp <= acc_resp;
            pend_data <= acc_data;
            lcnt      <= LAT_LOAD;
            state     <= StResp;
          end
        end
        StResp: begin
          // lcnt==0 marks the response cycle itself; leave for IDLE at its end.
          if (lcnt == 4'd0) begin
            ocp_scsu_m_sresp <= 2'd0;
            ocp_scsu_m_sdata <= 16'h0000;
            state            <= StIdle;
          end else begin
            lcnt <= lcnt - 4'd1;
            if (lcnt == 4'd1) begin
              ocp_scsu_m_sresp <= pend_resp;
              ocp_scsu_m_sdata <= pend_data;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
